// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared constants, counter helper and BTB entry type for the one-level predictor
package bpu_pkg;

    localparam int BPU_PC_W  = 32;
    localparam int BPU_IDX_W = 6;
    localparam int BPU_TAG_W = BPU_PC_W - BPU_IDX_W - 2;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [BPU_PC_W-1:0]  target;
        logic [1:0]           cnt;
    } btb_entry_t;

    function automatic logic [1:0] sat_cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_btb_ram.sv
// rtl/bpu_btb_ram.sv - direct-mapped BTB storage: async lookup read, update read, one write port
module bpu_btb_ram
    import bpu_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int IDX_W    = 6,
    parameter int TAG_W    = PC_WIDTH - IDX_W - 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [PC_WIDTH-1:0] rd_target,
    output logic [1:0]          rd_cnt,
    input  logic [IDX_W-1:0]    up_idx,
    output logic                up_valid,
    output logic [TAG_W-1:0]    up_tag,
    output logic [1:0]          up_cnt,
    input  logic                wr_en,
    input  logic                wr_target_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [PC_WIDTH-1:0] wr_target,
    input  logic [1:0]          wr_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem    [DEPTH];
    logic [PC_WIDTH-1:0] target_mem [DEPTH];
    logic [1:0]          cnt_mem    [DEPTH];

    // Only valid bits are reset; the payload arrays are qualified by valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            cnt_mem[wr_idx] <= wr_cnt;
        end
        if (wr_en && wr_target_en) begin
            target_mem[wr_idx] <= wr_target;
        end
    end

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = target_mem[rd_idx];
    assign rd_cnt    = cnt_mem[rd_idx];

    assign up_valid  = valid_q[up_idx];
    assign up_tag    = tag_mem[up_idx];
    assign up_cnt    = cnt_mem[up_idx];

endmodule

// File: rtl/bpu_one_level.sv
// rtl/bpu_one_level.sv - one-level BTB branch predictor with 2-bit counters for the fetch next-PC mux
module bpu_one_level
    import bpu_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int IDX_W    = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [PC_WIDTH-1:0] ifu_bpu_addr,
    input  logic                ifu_bpu_vaild,
    output logic [PC_WIDTH-1:0] bpu_ifu_npc,
    output logic                bpu_ifu_taken,
    input  logic                alu_bpu_upd_vld,
    input  logic [PC_WIDTH-1:0] alu_bpu_upd_pc,
    input  logic                alu_bpu_upd_taken,
    input  logic [PC_WIDTH-1:0] alu_bpu_upd_target
);

    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    up_tag_in;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [PC_WIDTH-1:0] rd_target;
    logic [1:0]          rd_cnt;
    logic                up_valid;
    logic [TAG_W-1:0]    up_tag;
    logic [1:0]          up_cnt;

    logic                lk_hit;
    logic                pred_taken;
    logic                up_hit;
    logic                wr_en;
    logic                wr_target_en;
    logic [1:0]          wr_cnt;

    logic                unused_addr_bits;

    assign lk_idx    = ifu_bpu_addr[IDX_W+1:2];
    assign lk_tag    = ifu_bpu_addr[PC_WIDTH-1:IDX_W+2];
    assign up_idx    = alu_bpu_upd_pc[IDX_W+1:2];
    assign up_tag_in = alu_bpu_upd_pc[PC_WIDTH-1:IDX_W+2];

    assign unused_addr_bits = ^{ifu_bpu_addr[1:0], alu_bpu_upd_pc[1:0]};

    bpu_btb_ram #(
        .PC_WIDTH (PC_WIDTH),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_btb (
        .clk          (clk),
        .rstn         (rstn),
        .rd_idx       (lk_idx),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_target    (rd_target),
        .rd_cnt       (rd_cnt),
        .up_idx       (up_idx),
        .up_valid     (up_valid),
        .up_tag       (up_tag),
        .up_cnt       (up_cnt),
        .wr_en        (wr_en),
        .wr_target_en (wr_target_en),
        .wr_idx       (up_idx),
        .wr_tag       (up_tag_in),
        .wr_target    (alu_bpu_upd_target),
        .wr_cnt       (wr_cnt)
    );

    // Lookup reads the tables combinationally, so a same-cycle update is not yet visible.
    assign lk_hit     = rd_valid && (rd_tag == lk_tag);
    assign pred_taken = lk_hit && rd_cnt[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bpu_ifu_npc   <= '0;
            bpu_ifu_taken <= 1'b0;
        end else if (ifu_bpu_vaild) begin
            bpu_ifu_npc   <= pred_taken ? rd_target : ifu_bpu_addr + PC_WIDTH'(4);
            bpu_ifu_taken <= pred_taken;
        end
    end

    assign up_hit = up_valid && (up_tag == up_tag_in);

    // Taken outcomes always write (train or allocate); not-taken only trains an existing entry.
    always_comb begin
        wr_en        = 1'b0;
        wr_target_en = 1'b0;
        wr_cnt       = CNT_WT;
        if (alu_bpu_upd_vld) begin
            if (alu_bpu_upd_taken) begin
                wr_en        = 1'b1;
                wr_target_en = 1'b1;
                wr_cnt       = up_hit ? sat_cnt_next(up_cnt, 1'b1) : CNT_WT;
            end else if (up_hit) begin
                wr_en        = 1'b1;
                wr_cnt       = sat_cnt_next(up_cnt, 1'b0);
            end
        end
    end

endmodule

// File: tb/tb_bpu_one_level.sv
// tb/tb_bpu_one_level.sv - self-checking bench for bpu_one_level against an entry-level reference model
module tb_bpu_one_level;
    import bpu_pkg::*;

    logic        clk;
    logic        rstn;
    logic [31:0] ifu_bpu_addr;
    logic        ifu_bpu_vaild;
    logic [31:0] bpu_ifu_npc;
    logic        bpu_ifu_taken;
    logic        alu_bpu_upd_vld;
    logic [31:0] alu_bpu_upd_pc;
    logic        alu_bpu_upd_taken;
    logic [31:0] alu_bpu_upd_target;

    int n_checks;
    int n_fail;

    btb_entry_t  m_tab [64];
    logic [31:0] m_npc;
    logic        m_taken;

    bpu_one_level #(.PC_WIDTH(32), .IDX_W(6)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .ifu_bpu_addr       (ifu_bpu_addr),
        .ifu_bpu_vaild      (ifu_bpu_vaild),
        .bpu_ifu_npc        (bpu_ifu_npc),
        .bpu_ifu_taken      (bpu_ifu_taken),
        .alu_bpu_upd_vld    (alu_bpu_upd_vld),
        .alu_bpu_upd_pc     (alu_bpu_upd_pc),
        .alu_bpu_upd_taken  (alu_bpu_upd_taken),
        .alu_bpu_upd_target (alu_bpu_upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tab[i].valid = 1'b0;
        m_npc   = 32'h0;
        m_taken = 1'b0;
    endtask

    // One clock: drive at negedge, apply lookup then update to the model at posedge, settle 1ns.
    task automatic step(input logic lv, input logic [31:0] la,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utg);
        int li;
        int ui;
        bit hit;
        @(negedge clk);
        ifu_bpu_vaild      = lv;
        ifu_bpu_addr       = la;
        alu_bpu_upd_vld    = uv;
        alu_bpu_upd_pc     = upc;
        alu_bpu_upd_taken  = ut;
        alu_bpu_upd_target = utg;
        @(posedge clk);
        if (lv) begin
            li  = int'(la[7:2]);
            hit = m_tab[li].valid && (m_tab[li].tag == la[31:8]);
            m_taken = hit && (m_tab[li].cnt >= 2);
            m_npc   = m_taken ? m_tab[li].target : la + 32'd4;
        end
        if (uv) begin
            ui  = int'(upc[7:2]);
            hit = m_tab[ui].valid && (m_tab[ui].tag == upc[31:8]);
            if (hit && ut) begin
                if (m_tab[ui].cnt < 3) m_tab[ui].cnt = m_tab[ui].cnt + 2'd1;
                m_tab[ui].target = utg;
            end else if (hit) begin
                if (m_tab[ui].cnt > 0) m_tab[ui].cnt = m_tab[ui].cnt - 2'd1;
            end else if (ut) begin
                m_tab[ui].valid  = 1'b1;
                m_tab[ui].tag    = upc[31:8];
                m_tab[ui].target = utg;
                m_tab[ui].cnt    = 2'd2;
            end
        end
        #1;
    endtask

    task automatic lookup(input logic [31:0] a);
        step(1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step(1'b0, 32'h0, 1'b1, pc, t, tg);
    endtask

    task automatic test_reset();
        n_checks++;
        if (bpu_ifu_npc !== 32'h0 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: npc=%h taken=%b want npc=0 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h104 || bpu_ifu_taken !== 1'b0 || m_npc !== 32'h104) begin
            n_fail++;
            $display("FAIL cold_lookup: npc=%h taken=%b want npc=104 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
    endtask

    task automatic test_train();
        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h200 || bpu_ifu_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL alloc_taken: npc=%h taken=%b want npc=200 taken=1", bpu_ifu_npc, bpu_ifu_taken);
        end
        update(32'h100, 1'b0, 32'h0);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h104 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL weak_nt: npc=%h taken=%b want npc=104 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        update(32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b0, 32'h0);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h104 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_low: npc=%h taken=%b want npc=104 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        // From 00 one taken reaches only 01; a second is needed to predict taken again.
        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h104 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL from_snt: npc=%h taken=%b want npc=104 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        for (int i = 0; i < 4; i++) update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h200 || bpu_ifu_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL strong_t: npc=%h taken=%b want npc=200 taken=1", bpu_ifu_npc, bpu_ifu_taken);
        end
        update(32'h100, 1'b0, 32'h0);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h200 || bpu_ifu_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_high: npc=%h taken=%b want npc=200 taken=1", bpu_ifu_npc, bpu_ifu_taken);
        end
    endtask

    task automatic test_alias();
        update(32'h200, 1'b1, 32'h300);
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h104 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_evict: npc=%h taken=%b want npc=104 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        lookup(32'h200);
        n_checks++;
        if (bpu_ifu_npc !== 32'h300 || bpu_ifu_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_new: npc=%h taken=%b want npc=300 taken=1", bpu_ifu_npc, bpu_ifu_taken);
        end
        update(32'h104, 1'b0, 32'h0);
        lookup(32'h104);
        n_checks++;
        if (bpu_ifu_npc !== 32'h108 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL nt_no_alloc: npc=%h taken=%b want npc=108 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h240);
        n_checks++;
        if (bpu_ifu_npc !== 32'h144 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL rbw_same: npc=%h taken=%b want npc=144 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        lookup(32'h140);
        n_checks++;
        if (bpu_ifu_npc !== 32'h240 || bpu_ifu_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw_after: npc=%h taken=%b want npc=240 taken=1", bpu_ifu_npc, bpu_ifu_taken);
        end
    endtask

    task automatic test_wrap_hold();
        lookup(32'hFFFF_FFFC);
        n_checks++;
        if (bpu_ifu_npc !== 32'h0 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: npc=%h taken=%b want npc=0 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        lookup(32'h200);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        n_checks++;
        if (bpu_ifu_npc !== 32'h300 || bpu_ifu_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL hold: npc=%h taken=%b want npc=300 taken=1", bpu_ifu_npc, bpu_ifu_taken);
        end
    endtask

    task automatic test_random();
        logic [31:0] la, upc, utg;
        for (int i = 0; i < 400; i++) begin
            la  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            utg = $urandom;
            step(1'($urandom_range(0, 1)), la, 1'($urandom_range(0, 1)), upc,
                 1'($urandom_range(0, 2) != 0), utg);
            n_checks++;
            if (bpu_ifu_npc !== m_npc || bpu_ifu_taken !== m_taken) begin
                n_fail++;
                $display("FAIL random[%0d]: npc=%h taken=%b want npc=%h taken=%b",
                         i, bpu_ifu_npc, bpu_ifu_taken, m_npc, m_taken);
            end
        end
    endtask

    task automatic test_reset_mid();
        update(32'h100, 1'b1, 32'h200);
        lookup(32'h100);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bpu_ifu_npc !== 32'h0 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: npc=%h taken=%b want npc=0 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        @(negedge clk);
        rstn = 1'b1;
        lookup(32'h100);
        n_checks++;
        if (bpu_ifu_npc !== 32'h104 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_miss: npc=%h taken=%b want npc=104 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
        lookup(32'h200);
        n_checks++;
        if (bpu_ifu_npc !== 32'h204 || bpu_ifu_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_miss2: npc=%h taken=%b want npc=204 taken=0", bpu_ifu_npc, bpu_ifu_taken);
        end
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        rstn               = 1'b0;
        ifu_bpu_addr       = 32'h0;
        ifu_bpu_vaild      = 1'b0;
        alu_bpu_upd_vld    = 1'b0;
        alu_bpu_upd_pc     = 32'h0;
        alu_bpu_upd_taken  = 1'b0;
        alu_bpu_upd_target = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_train();
        test_alias();
        test_same_cycle();
        test_wrap_hold();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
